stopwatch_up: RTL and testbench

- Count-up stopwatch. It is the complement of the countdown block and shares the same run/pause/clear control style and the same 17-bit seconds domain.
- Derives a 1 s tick from clk with an internal prescaler.
- Keeps elapsed seconds both as a binary total and as hours/minutes/seconds fields.
- Supports lap capture.
- Stops with a sticky overflow flag at a configurable maximum.
- Feeds the display mux and the buzzer logic in the clock top level.

---
 rtl/stopwatch_up.sv | 69 ++++++
 tb/tb_stopwatch_up.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_up.sv
// stopwatch_up: count-up stopwatch with prescaled 1 s tick, h/m/s fields, lap capture and sticky overflow
module stopwatch_up #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int MAX_SEC = 86399
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        pause,
  input  logic        clear,
  input  logic        lap,
  output logic [16:0] seconds,
  output logic [4:0]  hh,
  output logic [5:0]  mm,
  output logic [5:0]  ss,
  output logic [16:0] lap_sec,
  output logic        lap_valid,
  output logic        state,
  output logic        tick,
  output logic        overflow
);
  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] TOP = PW'(CLK_HZ - 1);
  localparam logic [16:0] MAX = 17'(MAX_SEC);
  localparam logic STOPPED = 1'b0;
  localparam logic RUNNING = 1'b1;
  logic [PW-1:0] presc;
  logic lap_q, fire, done, lap_edge, ss_wrap, mm_wrap;
  always_comb begin
    fire = state == RUNNING && presc == TOP;
    done = fire && seconds + 17'd1 == MAX;
    lap_edge = lap && !lap_q;
    ss_wrap = ss == 6'd59;
    mm_wrap = mm == 6'd59;
  end
  // terminal tick outranks run/pause so a coincident pause still ends in overflow
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      presc <= '0;
      lap_q <= 1'b0;
      seconds <= '0;
      hh <= '0;
      mm <= '0;
      ss <= '0;
      lap_sec <= '0;
      lap_valid <= 1'b0;
      state <= STOPPED;
      tick <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tick <= fire;
      lap_q <= lap;
      lap_valid <= lap_edge;
      if (lap_edge) lap_sec <= seconds;
      if (state == RUNNING) presc <= fire ? '0 : presc + 1'b1;
      if (fire) begin
        seconds <= seconds + 17'd1;
        ss <= ss_wrap ? 6'd0 : ss + 6'd1;
        mm <= ss_wrap ? (mm_wrap ? 6'd0 : mm + 6'd1) : mm;
        hh <= (ss_wrap && mm_wrap) ? hh + 5'd1 : hh;
      end
      if (done) begin
        state <= STOPPED;
        overflow <= 1'b1;
      end else if (state == STOPPED && run && !pause && !overflow) state <= RUNNING;
      else if (state == RUNNING && pause && !run) state <= STOPPED;
    end
  end
endmodule

// File: tb/tb_stopwatch_up.sv
// tb_stopwatch_up: two stopwatch configurations checked cycle by cycle against an arithmetic model
module tb_stopwatch_up;
  localparam int HZ [2] = '{4, 2};
  localparam int MX [2] = '{200, 3700};
  logic clk = 1'b0, rst = 1'b0, run = 1'b0, pause = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [16:0] sec_o [2];
  logic [4:0] hh_o [2];
  logic [5:0] mm_o [2];
  logic [5:0] ss_o [2];
  logic [16:0] lsec_o [2];
  logic lv_o [2], st_o [2], tk_o [2], ov_o [2];
  int total = 0, bad = 0;
  int m_run [2], m_ph [2], m_sec [2], m_ovf [2], m_lapq [2], m_lapsec [2], m_lapv [2], m_tk [2];
  always #5 clk = ~clk;
  stopwatch_up #(.CLK_HZ(4), .MAX_SEC(200)) u4 (
    .clk(clk), .rst(rst), .run(run), .pause(pause), .clear(clear), .lap(lap),
    .seconds(sec_o[0]), .hh(hh_o[0]), .mm(mm_o[0]), .ss(ss_o[0]), .lap_sec(lsec_o[0]),
    .lap_valid(lv_o[0]), .state(st_o[0]), .tick(tk_o[0]), .overflow(ov_o[0]));
  stopwatch_up #(.CLK_HZ(2), .MAX_SEC(3700)) u2 (
    .clk(clk), .rst(rst), .run(run), .pause(pause), .clear(clear), .lap(lap),
    .seconds(sec_o[1]), .hh(hh_o[1]), .mm(mm_o[1]), .ss(ss_o[1]), .lap_sec(lsec_o[1]),
    .lap_valid(lv_o[1]), .state(st_o[1]), .tick(tk_o[1]), .overflow(ov_o[1]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic finish_up();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask
  task automatic model_step(input int i, input bit r, input bit c, input bit ru, input bit pa, input bit lp);
    bit t, e;
    if (r || c) begin
      m_run[i] = 0; m_ph[i] = 0; m_sec[i] = 0; m_ovf[i] = 0;
      m_lapq[i] = 0; m_lapsec[i] = 0; m_lapv[i] = 0; m_tk[i] = 0;
    end else begin
      t = m_run[i] != 0 && m_ph[i] == HZ[i] - 1;
      e = lp && m_lapq[i] == 0;
      if (e) m_lapsec[i] = m_sec[i];
      m_lapv[i] = int'(e);
      m_lapq[i] = int'(lp);
      m_tk[i] = int'(t);
      if (m_run[i] != 0) m_ph[i] = (m_ph[i] + 1) % HZ[i];
      if (t) m_sec[i]++;
      if (t && m_sec[i] == MX[i]) begin
        m_run[i] = 0;
        m_ovf[i] = 1;
      end else if (m_run[i] == 0 && ru && !pa && m_ovf[i] == 0) m_run[i] = 1;
      else if (m_run[i] != 0 && pa && !ru) m_run[i] = 0;
    end
  endtask
  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d_seconds", i), 32'(sec_o[i]), 32'(m_sec[i]));
      check($sformatf("u%0d_hh", i), 32'(hh_o[i]), 32'(m_sec[i] / 3600));
      check($sformatf("u%0d_mm", i), 32'(mm_o[i]), 32'((m_sec[i] / 60) % 60));
      check($sformatf("u%0d_ss", i), 32'(ss_o[i]), 32'(m_sec[i] % 60));
      check($sformatf("u%0d_lap_sec", i), 32'(lsec_o[i]), 32'(m_lapsec[i]));
      check($sformatf("u%0d_lap_valid", i), 32'(lv_o[i]), 32'(m_lapv[i]));
      check($sformatf("u%0d_state", i), 32'(st_o[i]), 32'(m_run[i]));
      check($sformatf("u%0d_tick", i), 32'(tk_o[i]), 32'(m_tk[i]));
      check($sformatf("u%0d_overflow", i), 32'(ov_o[i]), 32'(m_ovf[i]));
    end
  endtask
  task automatic cyc(input bit r, input bit c, input bit ru, input bit pa, input bit lp);
    rst = r; clear = c; run = ru; pause = pa; lap = lp;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, r, c, ru, pa, lp);
    @(negedge clk);
    compare_all();
    if (bad > 50) finish_up();
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask
  initial begin
    int n, s0, exp_lap, pulses;
    for (int i = 0; i < 2; i++) model_step(i, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("reset_seconds", 32'(sec_o[0]), 0);
    check("reset_state", 32'(st_o[0]), 0);
    cyc(0, 0, 1, 0, 0);
    check("run_state", 32'(st_o[0]), 1);
    n = 0;
    do begin idle(); n++; end while (!tk_o[0] && n < 20);
    check("first_tick_gap", n, 4);
    repeat (36) idle();
    check("ten_ticks_sec", 32'(sec_o[0]), 10);
    check("ten_ticks_ss", 32'(ss_o[0]), 10);
    check("ten_ticks_mm", 32'(mm_o[0]), 0);
    idle();
    s0 = int'(sec_o[0]);
    repeat (7) cyc(0, 0, 0, 1, 0);
    check("pause_hold_sec", 32'(sec_o[0]), 32'(s0));
    check("pause_state", 32'(st_o[0]), 0);
    cyc(0, 0, 1, 0, 0);
    n = 0;
    do begin idle(); n++; end while (!tk_o[0] && n < 20);
    check("resume_tick_gap", n, 2);
    n = 0;
    while (!(m_run[0] != 0 && m_ph[0] == 3) && n < 20) begin idle(); n++; end
    exp_lap = m_sec[0];
    pulses = 0;
    repeat (10) begin cyc(0, 0, 0, 0, 1); pulses += int'(lv_o[0]); end
    check("lap_on_tick", 32'(lsec_o[0]), 32'(exp_lap));
    check("lap_pulses", pulses, 1);
    cyc(0, 0, 0, 1, 0);
    idle(); idle();
    exp_lap = int'(sec_o[0]) + 0;
    exp_lap = m_sec[0];
    cyc(0, 0, 0, 0, 1);
    check("lap_stopped_valid", 32'(lv_o[0]), 1);
    check("lap_stopped_sec", 32'(lsec_o[0]), 32'(exp_lap));
    idle();
    cyc(0, 0, 1, 1, 0);
    check("both_from_stopped", 32'(st_o[0]), 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    check("both_from_running", 32'(st_o[0]), 1);
    n = 0;
    while (m_ovf[1] == 0 && n < 10000) begin
      idle();
      n++;
      if (m_sec[1] == 3600 && m_tk[1] != 0) begin
        check("hour_carry_hh", 32'(hh_o[1]), 1);
        check("hour_carry_mm", 32'(mm_o[1]), 0);
        check("hour_carry_ss", 32'(ss_o[1]), 0);
      end
    end
    check("overflow_reached", 32'(ov_o[1]), 1);
    repeat (20) cyc(0, 0, 1, 0, 0);
    check("ovf_sec_u2", 32'(sec_o[1]), 3700);
    check("ovf_state_u2", 32'(st_o[1]), 0);
    check("ovf_sec_u4", 32'(sec_o[0]), 200);
    cyc(0, 1, 0, 0, 0);
    check("clear_sec", 32'(sec_o[1]), 0);
    check("clear_ovf", 32'(ov_o[1]), 0);
    check("clear_lap", 32'(lsec_o[1]), 0);
    cyc(0, 0, 1, 0, 0);
    n = 0;
    while (!(m_run[0] != 0 && m_ph[0] == 3) && n < 20) begin idle(); n++; end
    cyc(1, 0, 0, 0, 0);
    check("rst_term_tick", 32'(tk_o[0]), 0);
    check("rst_term_sec", 32'(sec_o[0]), 0);
    repeat (3) idle();
    check("rst_term_state", 32'(st_o[0]), 0);
    repeat (4000) cyc($urandom_range(0, 199) == 0, $urandom_range(0, 149) == 0,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
    finish_up();
  end
endmodule
